muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations that the single-cycle ALU does not execute.
- Sits beside the ALU in the execute stage and receives the same alucode, op1 and op2.
- Runs a 32-iteration shift-add multiplier or restoring divider under an FSM.
- Holds the pipeline with a stall signal until the result is ready.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per mul/div operation; must equal XLEN.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  execute stage presents a valid instruction this cycle.
- flush  in  1  kill the in-flight operation (branch/jump redirect).
- alucode  in  6  operation code; shared encoding with the ALU.
- op1  in  32  rs1 value (multiplicand / dividend).
- op2  in  32  rs2 value (multiplier / divisor).
- stall  out  1  freeze the PC and upstream pipeline registers.
- busy  out  1  FSM is not IDLE.
- result_valid  out  1  one-cycle pulse: result holds a completed value.
- result  out  32  mul/div/rem result.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0, result=0, result_valid=0, busy=0, stall=0, internal accumulators=0.
- is_md = alucode is one of ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - start && is_md && !flush -> latch the alucode and operand magnitudes, record result sign, cnt=0, go to BUSY.
  - Special divide cases go straight to DONE with result written.
  - All other inputs: remain in IDLE.
- BUSY:
  - One iteration per cycle, cnt increments.
  - When cnt==ITER-1, write the sign-corrected result and go to DONE.
  - start is ignored in BUSY.
- DONE: result_valid=1 for exactly this cycle, then IDLE. result holds its value until the next completion or reset.
- Latency:
  - Start sampled in cycle 0 -> result_valid in cycle ITER+1 (cycle 33).
  - Special divide cases -> result_valid in cycle 1.
- stall = (state==IDLE && start && is_md && !flush) || state==BUSY. stall is low in DONE so the execute stage retires with the result.
- busy = (state != IDLE).
- flush has priority over start and over normal FSM progress.
  - Any state -> IDLE on the next edge.
  - No result_valid pulse; result is unchanged.
- start with a non-M alucode: no effect, stall stays 0.
- Multiply:
  - Operands are converted to magnitudes. MULH: both signed. MULHSU: op1 signed, op2 unsigned. MULHU/MUL: unsigned (MUL low word is sign-agnostic).
  - 64-bit product; negate when the signs differ.
  - MUL returns bits [31:0]; MULH* return bits [63:32].
- Divide (restoring, unsigned on magnitudes):
  - Quotient sign = sign(op1) XOR sign(op2) for DIV.
  - Remainder sign = sign(op1) for REM.
  - DIVU/REMU are unsigned throughout.
- Special divide cases (resolved in IDLE, no iteration):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op1.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Reset asserted mid-operation: immediate return to the reset values; no partial result is visible.

Decomposition:
- define.vh (shared):
  - ALU_MUL..ALU_REMU alucode constants, unique 6-bit values not overlapping existing ALU codes.
  - ENABLE/DISABLE.
  - FSM state encodings MD_IDLE, MD_BUSY, MD_DONE.
- One sub-module, muldiv_step: combinational single iteration.
  - Inputs: mode (mul/div), accumulator, operand.
  - Outputs: next accumulator/quotient bits.
  - The top level owns the FSM, counter, sign handling and special cases.

Test Plan:
- MUL, op1=7, op2=6, start for 1 cycle -> stall=1 cycles 0..32, result_valid pulse in cycle 33, result=42, then busy=0.
- MULH, op1=0xFFFFFFFF, op2=0xFFFFFFFF -> result=0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU, op1=0xFFFFFFFF, op2=2 -> 0xFFFFFFFF.
- DIV, op1=-7 (0xFFFFFFF9), op2=2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIVU, op1=100, op2=7 -> 14. REMU same operands -> 2.
- DIV, op2=0, op1=5 -> result_valid in cycle 1, result=0xFFFFFFFF. REM, op1=5, op2=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- MUL started, flush asserted in cycle 10 -> IDLE in cycle 11, no result_valid, result keeps its prior value. A new start in cycle 12 completes normally in cycle 45.
- rst_n low in cycle 15 of a DIVU -> busy, stall and result_valid all 0 immediately. start with ALU_ADD -> stall stays 0 and the FSM stays IDLE.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multi-cycle multiply/divide sequencer:
// alucode constants, FSM states, iteration mode and decode helpers.
package muldiv_seq_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ITER_DEF = 32;

  // Base ALU code kept here so that the M-extension codes visibly avoid it.
  localparam logic [5:0] ALU_ADD    = 6'd0;

  // M-extension codes sit in a block that the single-cycle ALU never uses.
  localparam logic [5:0] ALU_MUL    = 6'd32;
  localparam logic [5:0] ALU_MULH   = 6'd33;
  localparam logic [5:0] ALU_MULHSU = 6'd34;
  localparam logic [5:0] ALU_MULHU  = 6'd35;
  localparam logic [5:0] ALU_DIV    = 6'd36;
  localparam logic [5:0] ALU_DIVU   = 6'd37;
  localparam logic [5:0] ALU_REM    = 6'd38;
  localparam logic [5:0] ALU_REMU   = 6'd39;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } md_mode_t;

  // True for every code this sequencer executes.
  function automatic logic is_md_op(input logic [5:0] code);
    return (code == ALU_MUL)  || (code == ALU_MULH) || (code == ALU_MULHSU) ||
           (code == ALU_MULHU) || (code == ALU_DIV)  || (code == ALU_DIVU)   ||
           (code == ALU_REM)  || (code == ALU_REMU);
  endfunction

  // True for the four divide-family codes.
  function automatic logic is_div_op(input logic [5:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU) ||
           (code == ALU_REM) || (code == ALU_REMU);
  endfunction

  // True when the remainder rather than the quotient is returned.
  function automatic logic is_rem_op(input logic [5:0] code);
    return (code == ALU_REM) || (code == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shift-add multiplier or the restoring
// divider. Both share a 64-bit accumulator {hi, lo}:
//   multiply: hi = partial product, lo = remaining multiplier bits
//   divide:   hi = partial remainder, lo = dividend bits / quotient bits
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  md_mode_t    mode,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] trial;

  // Add-then-shift-right for multiply; shift-left-then-trial-subtract for divide.
  always_comb begin
    sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    // The partial remainder is always below the divisor, so a non-negative
    // trial fits in 32 bits and bit 32 acts as the borrow flag.
    trial = {acc[63:32], acc[31]} - {1'b0, operand};
    if (mode == MODE_MUL) begin
      acc_next = {sum, acc[31:1]};
    end else if (!trial[32]) begin
      acc_next = {trial[31:0], acc[30:0], 1'b1};
    end else begin
      acc_next = {acc[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer beside the execute-stage ALU.
// Converts operands to magnitudes, runs ITER unsigned iterations, then
// applies the recorded sign. Divide-by-zero and signed overflow finish
// without iterating. The pipeline is stalled until the result is ready.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ITER = ITER_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [5:0]      alucode,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  md_state_t         state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [5:0]        op_reg, op_next;
  logic [2*XLEN-1:0] acc_reg, acc_next;
  logic [XLEN-1:0]   operand_reg, operand_next;
  logic              neg_reg, neg_next;
  logic [XLEN-1:0]   result_reg, result_next;

  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   final_res;
  logic              s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              start_md;
  logic              div_zero, div_ovf;
  md_mode_t          step_mode;

  assign step_mode = is_div_op(op_reg) ? MODE_DIV : MODE_MUL;

  muldiv_step u_step (
    .mode     (step_mode),
    .acc      (acc_reg),
    .operand  (operand_reg),
    .acc_next (step_acc)
  );

  // Operand decode for a new instruction: signedness, magnitudes, special cases.
  always_comb begin
    s1       = op1[XLEN-1] & ((alucode == ALU_MULH) || (alucode == ALU_MULHSU) ||
                              (alucode == ALU_DIV)  || (alucode == ALU_REM));
    s2       = op2[XLEN-1] & ((alucode == ALU_MULH) ||
                              (alucode == ALU_DIV)  || (alucode == ALU_REM));
    mag1     = s1 ? (~op1 + 1'b1) : op1;
    mag2     = s2 ? (~op2 + 1'b1) : op2;
    start_md = start && is_md_op(alucode) && !flush;
    div_zero = is_div_op(alucode) && (op2 == '0);
    div_ovf  = ((alucode == ALU_DIV) || (alucode == ALU_REM)) &&
               (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == {XLEN{1'b1}});
  end

  // Sign-corrected final result from the last iteration's accumulator.
  always_comb begin
    prod = neg_reg ? (~step_acc + 1'b1) : step_acc;
    if (is_div_op(op_reg)) begin
      if (is_rem_op(op_reg)) begin
        final_res = neg_reg ? (~step_acc[2*XLEN-1:XLEN] + 1'b1) : step_acc[2*XLEN-1:XLEN];
      end else begin
        final_res = neg_reg ? (~step_acc[XLEN-1:0] + 1'b1) : step_acc[XLEN-1:0];
      end
    end else if (op_reg == ALU_MUL) begin
      final_res = prod[XLEN-1:0];
    end else begin
      final_res = prod[2*XLEN-1:XLEN];
    end
  end

  // Next-state and datapath update; flush overrides everything.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_next      = op_reg;
    acc_next     = acc_reg;
    operand_next = operand_reg;
    neg_next     = neg_reg;
    result_next  = result_reg;
    if (flush) begin
      state_next = MD_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        MD_IDLE: begin
          if (start_md) begin
            op_next  = alucode;
            cnt_next = '0;
            if (div_zero) begin
              result_next = is_rem_op(alucode) ? op1 : {XLEN{1'b1}};
              state_next  = MD_DONE;
            end else if (div_ovf) begin
              result_next = is_rem_op(alucode) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              state_next  = MD_DONE;
            end else begin
              neg_next     = is_rem_op(alucode) ? s1 : (s1 ^ s2);
              acc_next     = {{XLEN{1'b0}}, (is_div_op(alucode) ? mag1 : mag2)};
              operand_next = is_div_op(alucode) ? mag2 : mag1;
              state_next   = MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          acc_next = step_acc;
          if (cnt_reg == CNT_LAST) begin
            cnt_next    = '0;
            result_next = final_res;
            state_next  = MD_DONE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        MD_DONE: begin
          state_next = MD_IDLE;
        end
        default: begin
          state_next = MD_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= MD_IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      acc_reg     <= '0;
      operand_reg <= '0;
      neg_reg     <= 1'b0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      op_reg      <= op_next;
      acc_reg     <= acc_next;
      operand_reg <= operand_next;
      neg_reg     <= neg_next;
      result_reg  <= result_next;
    end
  end

  // Pipeline handshake outputs.
  always_comb begin
    stall        = ((state_reg == MD_IDLE) && start_md) || (state_reg == MD_BUSY);
    busy         = (state_reg != MD_IDLE);
    result_valid = (state_reg == MD_DONE) ? ENABLE : DISABLE;
    result       = result_reg;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed results, latency, stall,
// flush and asynchronous reset behaviour.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  alucode = ALU_ADD;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .flush        (flush),
    .alucode      (alucode),
    .op1          (op1),
    .op2          (op2),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Called just after a rising edge; start is high in cycle 0.
  task automatic do_op(input string tag, input logic [5:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat = -1;
    int stall_cnt = 0;
    logic stall_done = 1'b1;
    start = 1'b1; alucode = code; op1 = a; op2 = b;
    for (int c = 0; c < 100 && lat < 0; c++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = c;
        stall_done = stall;
      end else if (stall) begin
        stall_cnt++;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_res"}, result, exp_res);
    check_val({tag, "_stallcyc"}, 32'(stall_cnt), 32'(exp_lat));
    check_val({tag, "_stalldone"}, {31'b0, stall_done}, 32'd0);
    @(negedge clk);
    check_val({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic rv_seen;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy",  {31'b0, busy}, 32'd0);
    check_val("rst_stall", {31'b0, stall}, 32'd0);
    check_val("rst_valid", {31'b0, result_valid}, 32'd0);
    check_val("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("mul_7x6",    ALU_MUL,    32'd7,          32'd6,          32'd42,         33);
    do_op("mulh_m1m1",  ALU_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   33);
    do_op("mulhu_m1m1", ALU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   33);
    do_op("mulhsu_m1x2",ALU_MULHSU, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   33);
    do_op("div_m7_2",   ALU_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33);
    do_op("rem_m7_2",   ALU_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33);
    do_op("divu_100_7", ALU_DIVU,   32'd100,        32'd7,          32'd14,         33);
    do_op("remu_100_7", ALU_REMU,   32'd100,        32'd7,          32'd2,          33);
    do_op("div_5_0",    ALU_DIV,    32'd5,          32'd0,          32'hFFFFFFFF,   1);
    do_op("rem_5_0",    ALU_REM,    32'd5,          32'd0,          32'd5,          1);
    do_op("div_ovf",    ALU_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1);
    do_op("rem_ovf",    ALU_REM,    32'h80000000,   32'hFFFFFFFF,   32'd0,          1);

    // Flush in cycle 10 of a MUL: no pulse, result keeps the last value (0).
    rv_seen = 1'b0;
    start = 1'b1; alucode = ALU_MUL; op1 = 32'd9; op2 = 32'd9;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (result_valid) rv_seen = 1'b1;
      if (c == 11) check_val("flush_busy_c11", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 9)  flush = 1'b1;
      if (c == 10) flush = 1'b0;
    end
    check_val("flush_no_valid", {31'b0, rv_seen}, 32'd0);
    check_val("flush_result_kept", result, 32'd0);
    // Restart in cycle 12, completes 33 cycles later (cycle 45).
    do_op("mul_after_flush", ALU_MUL, 32'h12345678, 32'h10, 32'h23456780, 33);

    // Non-M code: no stall, FSM stays idle.
    start = 1'b1; alucode = ALU_ADD; op1 = 32'd1; op2 = 32'd2;
    @(negedge clk);
    check_val("add_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_val("add_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in cycle 15 of a DIVU.
    start = 1'b1; alucode = ALU_DIVU; op1 = 32'd100; op2 = 32'd7;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_val("divu_busy_pre_rst", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy",   {31'b0, busy}, 32'd0);
    check_val("midrst_stall",  {31'b0, stall}, 32'd0);
    check_val("midrst_valid",  {31'b0, result_valid}, 32'd0);
    check_val("midrst_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("divu_after_rst", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
